imm_gen_stage: RTL



---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_format.sv | 57 +++++
 rtl/imm_gen_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: format select encodings and
// the datapath widths the generator supports.
package imm_pkg;

    localparam int SRC_W = 3;

    localparam logic [SRC_W-1:0] SRC_NONE  = 3'd0;
    localparam logic [SRC_W-1:0] SRC_I     = 3'd1;
    localparam logic [SRC_W-1:0] SRC_S     = 3'd2;
    localparam logic [SRC_W-1:0] SRC_B     = 3'd3;
    localparam logic [SRC_W-1:0] SRC_U     = 3'd4;
    localparam logic [SRC_W-1:0] SRC_J     = 3'd5;
    localparam logic [SRC_W-1:0] SRC_SHAMT = 3'd6;
    localparam logic [SRC_W-1:0] SRC_ZIMM  = 3'd7;

    // Only these two datapath widths are meaningful for the generator.
    localparam int XLEN_RV32 = 32;
    localparam int XLEN_RV64 = 64;

endpackage

// File: rtl/imm_format.sv
// Combinational immediate extractor: instruction bits [31:7] plus a format
// select give an XLEN-wide immediate and an "illegal for this XLEN" flag.
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]      instr_i,
    input  logic [SRC_W-1:0] src_i,
    output logic [XLEN-1:0]  imm_o,
    output logic             err_o
);

    localparam bit RV64 = (XLEN == XLEN_RV64);

    // instr_i[k] holds instruction bit k+7, so bit 31 is instr_i[24].
    logic        sgn;
    logic [31:0] v32;
    logic        zext;

    assign sgn = instr_i[24];

    always_comb begin
        v32   = '0;
        zext  = 1'b0;
        err_o = 1'b0;
        case (src_i)
            SRC_NONE:  v32 = '0;
            SRC_I:     v32 = {{20{sgn}}, instr_i[24:13]};
            SRC_S:     v32 = {{20{sgn}}, instr_i[24:18], instr_i[4:0]};
            SRC_B:     v32 = {{19{sgn}}, sgn, instr_i[0], instr_i[23:18],
                              instr_i[4:1], 1'b0};
            SRC_U:     v32 = {instr_i[24:5], 12'b0};
            SRC_J:     v32 = {{11{sgn}}, sgn, instr_i[12:5], instr_i[13],
                              instr_i[23:14], 1'b0};
            SRC_SHAMT: begin
                zext = 1'b1;
                if (RV64) begin
                    v32 = {26'b0, instr_i[18:13]};
                end else if (instr_i[18]) begin
                    err_o = 1'b1;
                end else begin
                    v32 = {27'b0, instr_i[17:13]};
                end
            end
            SRC_ZIMM: begin
                zext = 1'b1;
                v32  = {27'b0, instr_i[12:8]};
            end
            default:   v32 = '0;
        endcase
    end

    // v32 already carries the 32-bit sign extension; widen to XLEN here.
    assign imm_o = zext ? XLEN'(v32) : XLEN'($signed(v32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator between IF_ID and ID_EX with valid/ready
// handshakes. Define IMM_GEN_SKID_EN for a 2-entry skid buffer with registered in_ready.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int SRC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [SRC_W-1:0] in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err
);

    // Handshake: a beat moves on a port in any cycle where valid and ready are
    // both high; once offered, out_imm/out_err hold until out_ready is seen.
    logic [XLEN-1:0] fmt_imm;
    logic            fmt_err;

    imm_format #(.XLEN(XLEN)) u_fmt (
        .instr_i (in_instr),
        .src_i   (in_src),
        .imm_o   (fmt_imm),
        .err_o   (fmt_err)
    );

    logic            accept;
    logic            pop;
    logic            main_valid_q, main_valid_d;
    logic [XLEN-1:0] main_imm_q,   main_imm_d;
    logic            main_err_q,   main_err_d;

    assign accept = in_valid && in_ready && !flush;
    assign pop    = main_valid_q && out_ready;

`ifdef IMM_GEN_SKID_EN
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic            skid_err_q,   skid_err_d;
    logic            in_ready_q;

    // in_ready_q mirrors an empty skid slot one cycle late, so it never
    // depends on out_ready within a cycle.
    assign in_ready = in_ready_q && !rst;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_imm_d = fmt_imm;
                    main_err_d = fmt_err;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = fmt_imm;
            skid_err_d   = fmt_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= !skid_valid_d;
        end
    end
`else
    assign in_ready = !rst && (!main_valid_q || out_ready);

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_err_d   = main_err_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            main_valid_d = accept;
            if (accept) begin
                main_imm_d = fmt_imm;
                main_err_d = fmt_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_err_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_err_q   <= main_err_d;
        end
    end
`endif

    // Idle outputs read as zero so ID_EX never sees a stale immediate.
    assign out_valid = main_valid_q;
    assign out_imm   = main_valid_q ? main_imm_q : '0;
    assign out_err   = main_valid_q && main_err_q;

endmodule
